// File: rtl/display_mux_scheduler.sv
// rtl/display_mux_scheduler.sv - time-multiplexed hex digit scheduler with dead-time blanking
// and a frame-synchronous double-buffered digit load.
module display_mux_scheduler #(
  parameter int NUM_DIGITS   = 2,
  parameter int ON_CYCLES    = 2400,
  parameter int BLANK_CYCLES = 48
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              cur_digit,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_done
);

  localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        idx_nxt;
  logic [3:0]              cur_q, cur_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] sel_shift;
  logic                    pending_q, pending_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      cur_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      cur_q     <= cur_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    cur_d      = cur_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    pending_d  = pending_q;
    anode_n    = '1;
    frame_done = 1'b0;
    idx_nxt    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    sel_shift  = '0;

    // Shadow only accepts while nothing is waiting; commit and accept never coincide.
    if (load_valid && !pending_q) begin
      shadow_d  = digits_in;
      pending_d = 1'b1;
    end

    case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      S_ON: begin
        anode_n[idx_q] = ~digit_en[idx_q];
        if (cnt_q == ON_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = idx_nxt;
          if (idx_q == IDX_LAST) begin
            frame_done = 1'b1;
            if (pending_q) begin
              active_d  = shadow_q;
              pending_d = 1'b0;
            end
          end
          // Latch the next slot's value so it holds through its whole BLANK+ON window.
          sel_shift = active_d >> {idx_nxt, 2'b00};
          cur_d     = sel_shift[3:0];
        end
      end
      default: state_d = S_BLANK;
    endcase
  end

  assign cur_digit  = cur_q;
  assign load_ready = ~pending_q;

endmodule

// File: tb/tb_display_mux_scheduler.sv
// tb/tb_display_mux_scheduler.sv - table-driven check of slot timing, double-buffered loads
// and async reset for display_mux_scheduler.
module tb_display_mux_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] digits_in;
  logic       load_valid;
  logic       load_ready;
  logic [1:0] digit_en;
  logic [3:0] cur_digit;
  logic [1:0] anode_n;
  logic       frame_done;

  display_mux_scheduler #(
    .NUM_DIGITS  (2),
    .ON_CYCLES   (4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digits_in (digits_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .digit_en  (digit_en),
    .cur_digit (cur_digit),
    .anode_n   (anode_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       vld;
    logic [1:0] en;
    logic [1:0] an;
    logic [3:0] cur;
    logic       fd;
    logic       rdy;
  } vec_t;

  vec_t tbl [48];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs from slot phase p (0..11): blank 0-1, digit0 on 2-5, blank 6-7, digit1 on 8-11.
  function automatic vec_t mk(input int p, input logic [1:0] en, input logic [3:0] c0,
                              input logic [3:0] c1, input logic rdy);
    vec_t v;
    v.din = 8'h00;
    v.vld = 1'b0;
    v.en  = en;
    if (p < 2)      v.an = 2'b11;
    else if (p < 6) v.an = {1'b1, ~en[0]};
    else if (p < 8) v.an = 2'b11;
    else            v.an = {~en[1], 1'b1};
    v.cur = (p < 6) ? c0 : c1;
    v.fd  = (p == 11);
    v.rdy = rdy;
    return v;
  endfunction

  task automatic check_vec(input string tag, input int c, input vec_t v);
    chk({tag, ".anode_n"}, c, {6'd0, anode_n}, {6'd0, v.an});
    chk({tag, ".cur_digit"}, c, {4'd0, cur_digit}, {4'd0, v.cur});
    chk({tag, ".frame_done"}, c, {7'd0, frame_done}, {7'd0, v.fd});
    chk({tag, ".load_ready"}, c, {7'd0, load_ready}, {7'd0, v.rdy});
  endtask

  initial begin
    for (int c = 0; c < 12; c++) tbl[c]      = mk(c, 2'b11, 4'h0, 4'h0, (c <= 3));
    for (int c = 0; c < 12; c++) tbl[12 + c] = mk(c, 2'b01, 4'hA, 4'h5, 1'b1);
    for (int c = 0; c < 12; c++) tbl[24 + c] = mk(c, 2'b11, 4'hA, 4'h5, 1'b0);
    for (int c = 0; c < 12; c++) tbl[36 + c] = mk(c, 2'b10, 4'h3, 4'hC, 1'b1);
    tbl[3].vld  = 1'b1; tbl[3].din  = 8'h5A;
    tbl[6].vld  = 1'b1; tbl[6].din  = 8'h33;
    tbl[23].vld = 1'b1; tbl[23].din = 8'hC3;
    tbl[30].vld = 1'b1; tbl[30].din = 8'h77;
    tbl[45].en  = 2'b00; tbl[45].an = 2'b11;

    reset      = 1'b1;
    digits_in  = 8'h00;
    load_valid = 1'b0;
    digit_en   = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.anode_n", -1, {6'd0, anode_n}, 8'h03);
    chk("reset.cur_digit", -1, {4'd0, cur_digit}, 8'h00);
    chk("reset.frame_done", -1, {7'd0, frame_done}, 8'h00);
    chk("reset.load_ready", -1, {7'd0, load_ready}, 8'h01);

    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 48; c++) begin
      digits_in  = tbl[c].din;
      load_valid = tbl[c].vld;
      digit_en   = tbl[c].en;
      #1;
      check_vec("tbl", c, tbl[c]);
      @(negedge clk);
    end

    // Pending load, then async reset mid-ON: anodes drop before the next edge, load discarded.
    reset = 1'b1;
    load_valid = 1'b0;
    digit_en = 2'b11;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      load_valid = (c == 3);
      digits_in  = 8'h5A;
      @(negedge clk);
    end
    load_valid = 1'b0;
    #1;
    chk("rst6.pre_anode_n", 4, {6'd0, anode_n}, 8'h02);
    chk("rst6.pre_load_ready", 4, {7'd0, load_ready}, 8'h00);
    #1 reset = 1'b1;
    #1;
    chk("rst6.anode_n", 4, {6'd0, anode_n}, 8'h03);
    chk("rst6.load_ready", 4, {7'd0, load_ready}, 8'h01);
    chk("rst6.cur_digit", 4, {4'd0, cur_digit}, 8'h00);
    chk("rst6.frame_done", 4, {7'd0, frame_done}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 14; c++) begin
      #1;
      check_vec("post_rst", c, mk(c % 12, 2'b11, 4'h0, 4'h0, 1'b1));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
